// File: rtl/waveform_capture.sv
// Waveform capture: trigger detection, ping-pong trace memory, column-aligned readout.
// Optional build macro WAVEFORM_CAPTURE_AUTO_TRIG_EN adds a forced capture after
// AUTO_TIMEOUT untriggered valid samples in WAIT_TRIG.
module waveform_capture #(
    parameter int unsigned DEPTH        = 751,
    parameter int unsigned X_START      = 20,
    parameter int unsigned REFRESH_Y    = 770,
    parameter int unsigned AUTO_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] sample,
    input  logic        sample_valid,
    input  logic [11:0] trig_level,
    input  logic        trig_slope,
    input  logic        single,
    input  logic        rearm,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    output logic [11:0] data,
    output logic        armed,
    output logic        capturing,
    output logic        trace_valid
);

    localparam int unsigned DW  = 12;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned XW  = 11;
    localparam int unsigned XNW = XW + 1;
    localparam int unsigned YW  = 10;

    localparam logic [1:0] S_WAIT_TRIG = 2'd0;
    localparam logic [1:0] S_CAPTURE   = 2'd1;
    localparam logic [1:0] S_HOLD      = 2'd2;
    localparam logic [1:0] S_STOPPED   = 2'd3;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [DW-1:0] prev_sample_q, prev_sample_d;
    logic          prev_ok_q, prev_ok_d;
    logic          full_q, full_d;
    logic          trace_valid_q, trace_valid_d;
    logic          armed_q, armed_d;
    logic          capturing_q, capturing_d;
    logic          win_q, win_d;
    logic [DW-1:0] ram_rd_q, ram_rd_d;

    logic          refresh_c;
    logic          trig_c;
    logic          auto_c;
    logic          we_c;
    logic [AW-1:0] wa_c;
    logic [XNW-1:0] x_next_c;
    logic [XW-1:0] rd_addr_c;
    logic [AW-1:0] rd_idx_c;

    // Frame refresh strobe and edge-trigger condition on the current sample
    always_comb begin
        refresh_c = (x == '0) && (y == YW'(REFRESH_Y));
        if (trig_slope) begin
            trig_c = prev_ok_q && (prev_sample_q > trig_level) && (sample <= trig_level);
        end else begin
            trig_c = prev_ok_q && (prev_sample_q < trig_level) && (sample >= trig_level);
        end
    end

`ifdef WAVEFORM_CAPTURE_AUTO_TRIG_EN
    localparam int unsigned CW = $clog2(AUTO_TIMEOUT + 1);
    logic [CW-1:0] to_cnt_q, to_cnt_d;

    // Untriggered sample counter, zero whenever the FSM is outside WAIT_TRIG
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q != S_WAIT_TRIG) begin
            to_cnt_d = '0;
        end else if (sample_valid && (to_cnt_q != CW'(AUTO_TIMEOUT))) begin
            to_cnt_d = to_cnt_q + CW'(1);
        end
        auto_c = (to_cnt_q == CW'(AUTO_TIMEOUT));
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign auto_c = 1'b0;
`endif

    // Capture FSM next state, write strobe and bank swap
    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        prev_sample_d = prev_sample_q;
        prev_ok_d     = prev_ok_q;
        full_d        = full_q;
        trace_valid_d = trace_valid_q;
        we_c          = 1'b0;
        wa_c          = wr_addr_q;
        unique case (state_q)
            S_WAIT_TRIG: begin
                if (sample_valid) begin
                    prev_sample_d = sample;
                    prev_ok_d     = 1'b1;
                    if (trig_c || auto_c) begin
                        we_c      = 1'b1;
                        wa_c      = '0;
                        wr_addr_d = AW'(1);
                        state_d   = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (sample_valid) begin
                    we_c = 1'b1;
                    if (wr_addr_q == LAST_ADDR) begin
                        full_d    = 1'b1;
                        wr_addr_d = '0;
                        state_d   = S_HOLD;
                    end else begin
                        wr_addr_d = wr_addr_q + AW'(1);
                    end
                end
            end
            S_HOLD: begin
                if (refresh_c && full_q) begin
                    rd_bank_d     = wr_bank_q;
                    wr_bank_d     = rd_bank_q;
                    trace_valid_d = 1'b1;
                    full_d        = 1'b0;
                    if (single) begin
                        state_d = S_STOPPED;
                    end else begin
                        state_d   = S_WAIT_TRIG;
                        prev_ok_d = 1'b0;
                    end
                end
            end
            S_STOPPED: begin
                if (rearm) begin
                    state_d   = S_WAIT_TRIG;
                    prev_ok_d = 1'b0;
                end
            end
            default: begin
                state_d = S_WAIT_TRIG;
            end
        endcase
        armed_d     = (state_d == S_WAIT_TRIG);
        capturing_d = (state_d == S_CAPTURE);
    end

    // Read lookahead: fetch column x+1 so the registered output lines up with x
    always_comb begin
        x_next_c  = {1'b0, x} + XNW'(1);
        rd_addr_c = XW'(x + XW'(1) - XW'(X_START));
        win_d     = (x_next_c >= XNW'(X_START)) &&
                    (x_next_c <= XNW'(X_START + DEPTH - 1)) && trace_valid_q;
        rd_idx_c  = win_d ? AW'(rd_addr_c) : '0;
        ram_rd_d  = rd_bank_q ? mem1[rd_idx_c] : mem0[rd_idx_c];
    end

    // Control and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_WAIT_TRIG;
            wr_addr_q     <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b1;
            prev_sample_q <= '0;
            prev_ok_q     <= 1'b0;
            full_q        <= 1'b0;
            trace_valid_q <= 1'b0;
            armed_q       <= 1'b1;
            capturing_q   <= 1'b0;
            win_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            prev_sample_q <= prev_sample_d;
            prev_ok_q     <= prev_ok_d;
            full_q        <= full_d;
            trace_valid_q <= trace_valid_d;
            armed_q       <= armed_d;
            capturing_q   <= capturing_d;
            win_q         <= win_d;
        end
    end

    // Sample memory write port and registered read port (no reset on RAM paths)
    always_ff @(posedge clk) begin
        if (we_c) begin
            if (wr_bank_q) begin
                mem1[wa_c] <= sample;
            end else begin
                mem0[wa_c] <= sample;
            end
        end
        ram_rd_q <= ram_rd_d;
    end

    assign data        = win_q ? ram_rd_q : '0;
    assign armed       = armed_q;
    assign capturing   = capturing_q;
    assign trace_valid = trace_valid_q;

endmodule

// File: tb/tb_waveform_capture.sv
// Testbench for waveform_capture: randomized sample streams checked against a
// trace model derived from the trigger rules (first crossing in the valid-sample list).
module tb_waveform_capture;

    localparam int DEPTH = 751;
    localparam int XS    = 20;
    localparam int RY    = 770;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [11:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic [11:0] trig_level = 12'd2048;
    logic        trig_slope = 1'b0;
    logic        single = 1'b0;
    logic        rearm = 1'b0;
    logic [10:0] x = 11'd1;
    logic [9:0]  y = '0;
    logic [11:0] data;
    logic        armed;
    logic        capturing;
    logic        trace_valid;

    int n_pass  = 0;
    int n_total = 0;

    int q[$];
    int disp[DEPTH];
    int pend[DEPTH];
    bit disp_ok = 1'b0;

    waveform_capture dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .single       (single),
        .rearm        (rearm),
        .x            (x),
        .y            (y),
        .data         (data),
        .armed        (armed),
        .capturing    (capturing),
        .trace_valid  (trace_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic [11:0] s, input logic v, input logic [10:0] xx,
                         input logic [9:0] yy, input logic ra);
        @(posedge clk);
        #1;
        sample       = s;
        sample_valid = v;
        x            = xx;
        y            = yy;
        rearm        = ra;
    endtask

    task automatic idle_cyc();
        drive(12'd0, 1'b0, 11'd1, 10'd0, 1'b0);
    endtask

    task automatic refresh_cyc();
        drive(12'd0, 1'b0, 11'd0, 10'(RY), 1'b0);
        idle_cyc();
    endtask

    // Sweep x across the line and compare each column against the displayed trace model
    task automatic scan(input string tag);
        int e;
        drive(12'd0, 1'b0, 11'd0, 10'd0, 1'b0);
        for (int xi = 1; xi < 800; xi++) begin
            drive(12'd0, 1'b0, 11'(xi), 10'd0, 1'b0);
            e = (disp_ok && xi >= XS && xi < XS + DEPTH) ? disp[xi - XS] : 0;
            check($sformatf("%s x=%0d", tag, xi), 32'(data), e);
        end
        idle_cyc();
    endtask

    // First valid-sample index that satisfies the crossing rule; index 0 never triggers
    function automatic int find_trig(input int lvl, input bit falling);
        for (int i = 1; i < q.size(); i++) begin
            if (!falling && q[i-1] < lvl && q[i] >= lvl) return i;
            if (falling && q[i-1] > lvl && q[i] <= lvl) return i;
        end
        return -1;
    endfunction

    // Stream q with random idle gaps; optional refresh after sample ref_at is consumed
    task automatic feed(input string tag, input int ref_at);
        for (int i = 0; i < q.size(); i++) begin
            if ($urandom_range(0, 3) == 0) idle_cyc();
            drive(12'(q[i]), 1'b1, 11'd1, 10'd0, 1'b0);
            if (i == ref_at) begin
                drive(12'd0, 1'b0, 11'd0, 10'(RY), 1'b0);
                idle_cyc();
                check({tag, " midcap trace_valid"}, 32'(trace_valid), 32'(disp_ok));
                check({tag, " midcap capturing"}, 32'(capturing), 32'd1);
            end
        end
        idle_cyc();
    endtask

    initial begin
        int t;
        int v;
        int step;

        // Reset
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst armed", 32'(armed), 32'd1);
        check("rst capturing", 32'(capturing), 32'd0);
        check("rst trace_valid", 32'(trace_valid), 32'd0);
        check("rst data", 32'(data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Refresh while armed changes nothing; no trace displayed yet
        refresh_cyc();
        check("wait refresh trace_valid", 32'(trace_valid), 32'd0);
        check("wait refresh armed", 32'(armed), 32'd1);
        scan("pre");

        // Rising trigger on a ramp, refresh injected at wr_addr = 300
        trig_level = 12'd2048;
        trig_slope = 1'b0;
        q.delete();
        for (int i = 0; i < 256 + DEPTH + 4; i++) q.push_back((i * 8) % 4096);
        t = find_trig(2048, 1'b0);
        for (int k = 0; k < DEPTH; k++) pend[k] = q[t + k];
        feed("rise", t + 299);
        check("rise hold capturing", 32'(capturing), 32'd0);
        check("rise hold armed", 32'(armed), 32'd0);
        check("rise hold trace_valid", 32'(trace_valid), 32'd0);
        refresh_cyc();
        disp = pend;
        disp_ok = 1'b1;
        check("rise swap trace_valid", 32'(trace_valid), 32'd1);
        check("rise swap armed", 32'(armed), 32'd1);
        scan("rise");

        // Falling slope, single mode; first sample after arming must not trigger
        single = 1'b1;
        trig_slope = 1'b1;
        step = $urandom_range(4, 12);
        q.delete();
        q.push_back(100);
        v = 4000;
        for (int i = 0; i < 500 + DEPTH; i++) begin
            q.push_back(v);
            v = (v + 4096 - step) % 4096;
        end
        t = find_trig(2048, 1'b1);
        for (int k = 0; k < DEPTH; k++) pend[k] = q[t + k];
        feed("fall", t + 299);
        scan("fall hold");
        refresh_cyc();
        disp = pend;
        check("fall swap trace_valid", 32'(trace_valid), 32'd1);
        check("fall stopped armed", 32'(armed), 32'd0);
        check("fall stopped capturing", 32'(capturing), 32'd0);
        drive(12'd0, 1'b0, 11'd19, 10'd0, 1'b0);
        drive(12'd0, 1'b0, 11'd20, 10'd0, 1'b0);
        check("fall first <= level", 32'(data <= 12'd2048), 32'd1);
        scan("fall");

        // Trigger events while stopped are ignored; refresh does not swap
        for (int i = 0; i < 20; i++) begin
            drive((i % 2 == 0) ? 12'd3000 : 12'd1000, 1'b1, 11'd1, 10'd0, 1'b0);
        end
        idle_cyc();
        check("stopped armed", 32'(armed), 32'd0);
        check("stopped capturing", 32'(capturing), 32'd0);
        refresh_cyc();
        check("stopped trace_valid", 32'(trace_valid), 32'd1);
        scan("stopped");
        drive(12'd0, 1'b0, 11'd1, 10'd0, 1'b1);
        idle_cyc();
        check("rearm armed", 32'(armed), 32'd1);

        // Asynchronous reset in the middle of a capture
        single = 1'b0;
        trig_slope = 1'b0;
        q.delete();
        for (int i = 0; i < 300; i++) q.push_back((i * 8) % 4096);
        feed("arst", -1);
        check("arst pre capturing", 32'(capturing), 32'd1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst capturing", 32'(capturing), 32'd0);
        check("arst trace_valid", 32'(trace_valid), 32'd0);
        check("arst armed", 32'(armed), 32'd1);
        check("arst data", 32'(data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        disp_ok = 1'b0;

        // Flat input: auto trigger after the timeout only when the feature is built in
`ifdef WAVEFORM_CAPTURE_AUTO_TRIG_EN
        for (int i = 0; i < 4096; i++) drive(12'd1000, 1'b1, 11'd1, 10'd0, 1'b0);
        idle_cyc();
        check("auto before armed", 32'(armed), 32'd1);
        check("auto before capturing", 32'(capturing), 32'd0);
        drive(12'd1000, 1'b1, 11'd1, 10'd0, 1'b0);
        idle_cyc();
        check("auto capturing", 32'(capturing), 32'd1);
`else
        for (int i = 0; i < 5000; i++) drive(12'd1000, 1'b1, 11'd1, 10'd0, 1'b0);
        idle_cyc();
        check("flat armed", 32'(armed), 32'd1);
        check("flat capturing", 32'(capturing), 32'd0);
`endif
        scan("post reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/waveform_capture.md
Name: waveform_capture

Overview:
- Writer end of the scope sample path: accepts ADC samples, detects a trigger, and records DEPTH consecutive samples into a ping-pong sample memory.
- During scan-out it returns one 12-bit sample per column on data, aligned to the pixel x/y counters. This is the data input consumed by the waveform pixel generator.
- Bank swap happens only at the frame refresh strobe, so a frame never shows a half-written trace.

Parameters:
- DEPTH, 751, samples per trace; one per column of the plot window.
- X_START, 20, first plot column; sample k is shown at x = X_START + k.
- REFRESH_Y, 770, scan line of the refresh strobe; refresh = (x == 0) && (y == REFRESH_Y).
- AUTO_TIMEOUT, 4096, valid samples without a trigger before a forced capture (optional feature only).

Ports:
- clk  input  1  pixel/system clock.
- reset_n  input  1  asynchronous, active-low reset.
- sample  input  12  ADC sample, unsigned.
- sample_valid  input  1  sample is qualified this cycle; one-cycle strobe, any rate up to every cycle.
- trig_level  input  12  trigger threshold, unsigned.
- trig_slope  input  1  0 = rising edge, 1 = falling edge.
- single  input  1  1 = stop after one capture until rearm.
- rearm  input  1  one-cycle pulse that restarts capture in single mode.
- x  input  11  pixel column counter.
- y  input  10  pixel row counter.
- data  output  12  sample for the current column; 0 outside the window or before the first trace.
- armed  output  1  high in WAIT_TRIG.
- capturing  output  1  high in CAPTURE.
- trace_valid  output  1  read bank holds a complete trace.

Behaviour:
- Reset (asynchronous assert): state = WAIT_TRIG, wr_addr = 0, wr_bank = 0, rd_bank = 1, prev_ok = 0, full = 0, trace_valid = 0, data = 0, armed = 1, capturing = 0. Memory contents are don't-care.
- Memory: two banks of DEPTH x 12 bits. Write port uses wr_bank; read port uses rd_bank. Each bank is one inferred simple dual-port RAM.
- FSM states: WAIT_TRIG, CAPTURE, HOLD, STOPPED.
- WAIT_TRIG:
  - On every valid sample, latch prev_sample <= sample and set prev_ok <= 1.
  - Trigger fires on a valid sample when prev_ok = 1 and:
    - rising: prev_sample < trig_level && sample >= trig_level;
    - falling: prev_sample > trig_level && sample <= trig_level.
  - The triggering sample is written at address 0, wr_addr <= 1, and the FSM goes to CAPTURE.
  - prev_ok is cleared on every entry to WAIT_TRIG, so the first sample after arming never triggers.
- CAPTURE:
  - Each valid sample is written at wr_addr, then wr_addr increments.
  - The write at wr_addr == DEPTH-1 sets full = 1, wr_addr <= 0, and moves to HOLD.
  - Cycles without sample_valid write nothing.
- HOLD: ignores samples and waits for refresh.
- Refresh in HOLD with full = 1:
  - swap: rd_bank <= wr_bank, wr_bank <= rd_bank;
  - set trace_valid <= 1 and clear full <= 0;
  - go to STOPPED if single = 1, otherwise to WAIT_TRIG.
- Refresh in WAIT_TRIG or CAPTURE: no swap, no state change; the previous trace stays displayed.
- STOPPED: a rearm pulse moves to WAIT_TRIG. rearm in any other state is ignored.
- Simultaneous refresh and completing write in the same cycle: the write completes and the FSM enters HOLD; the swap waits for the next refresh, one frame later.
- Read path:
  - Address = x + 1 - X_START, 11-bit.
  - The registered RAM output is qualified by a registered window flag: (x + 1) in [X_START, X_START + DEPTH - 1] and trace_valid = 1.
  - data for column x is therefore valid in the same cycle x is presented (1-cycle RAM latency absorbed by the +1 lookahead).
  - y does not gate data. Row clipping belongs to the pixel generator.
- Status outputs are registered versions of the state decode.
- Reset during CAPTURE: immediate return to the reset state. trace_valid falls, so data reads 0 until a new trace is swapped in.

Optional Feature:
- Macro: WAVEFORM_CAPTURE_AUTO_TRIG_EN.
- Defined: a counter clears on entry to WAIT_TRIG and increments per valid sample in WAIT_TRIG. When it reaches AUTO_TIMEOUT, the next valid sample starts CAPTURE as if triggered, giving a free-running trace for flat signals.
- Not defined: the counter and the AUTO_TIMEOUT logic are absent, and WAIT_TRIG waits indefinitely.

Test Plan:
- Rising trigger: reset, trig_level = 2048, ramp 0..4095 step 8 with sample_valid every cycle.
  - Expected: trigger on sample 2048; after the next refresh, data at x = 20 is 2048, at x = 21 is 2056, at x = 770 is 2048 + 750*8 mod 4096.
- Falling slope plus arming rule: trig_slope = 1, first sample after arming = 100 with level 2048, then a falling ramp.
  - Expected: no trigger on that first sample; the first stored value is <= 2048.
- Refresh mid-capture: assert refresh at wr_addr = 300.
  - Expected: rd_bank, trace_valid and displayed data unchanged; swap occurs at the first refresh after full = 1.
- Window edges: x = 18, 19, 771 give data 0; x = 20 gives stored sample 0; x = 770 gives sample 750. Before the first swap, data = 0 for all x.
- Single mode: single = 1 with two trigger events.
  - Expected: one swap, then STOPPED ignores triggers; a rearm pulse re-enters WAIT_TRIG (armed = 1 the next cycle).
- Async reset mid-capture: drop reset_n between clock edges.
  - Expected: capturing = 0 and trace_valid = 0 immediately; with WAVEFORM_CAPTURE_AUTO_TRIG_EN and a constant input of 1000, capture begins after 4096 valid samples.
